// File: rtl/prewitt_frame_sequencer_if.sv
// Bus bundle between the Prewitt frame sequencer and its frame RAMs,
// window/gradient datapath and shared divider.
interface prewitt_frame_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  // input-frame RAM read port
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [7:0]        in_rd_data;
  // raster pixel stream to the window datapath
  logic              px_valid;
  logic [7:0]        px_data;
  logic [ADDR_W-1:0] px_row;
  logic [ADDR_W-1:0] px_col;
  // magnitudes returned by the gradient unit
  logic              mag_valid;
  logic [10:0]       mag;
  // intermediate magnitude RAM
  logic              mid_wr_en;
  logic [ADDR_W-1:0] mid_wr_addr;
  logic [10:0]       mid_wr_data;
  logic              mid_rd_en;
  logic [ADDR_W-1:0] mid_rd_addr;
  logic [10:0]       mid_rd_data;
  // shared divider
  logic              div_req;
  logic [18:0]       div_num;
  logic [10:0]       div_den;
  logic              div_ack;
  logic [7:0]        div_quot;
  // output-frame RAM write port
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [7:0]        out_wr_data;

  modport master (
    output in_rd_en, in_rd_addr, px_valid, px_data, px_row, px_col,
           mid_wr_en, mid_wr_addr, mid_wr_data, mid_rd_en, mid_rd_addr,
           div_req, div_num, div_den, out_wr_en, out_wr_addr, out_wr_data,
    input  in_rd_data, mag_valid, mag, mid_rd_data, div_ack, div_quot
  );

  modport slave (
    input  in_rd_en, in_rd_addr, px_valid, px_data, px_row, px_col,
           mid_wr_en, mid_wr_addr, mid_wr_data, mid_rd_en, mid_rd_addr,
           div_req, div_num, div_den, out_wr_en, out_wr_addr, out_wr_data,
    output in_rd_data, mag_valid, mag, mid_rd_data, div_ack, div_quot
  );
endinterface

// File: rtl/prewitt_frame_sequencer.sv
// Two-pass frame controller for Prewitt edge detection: pass 1 streams the
// frame to the gradient datapath and stores magnitudes (border forced to 0)
// while tracking the maximum; pass 2 normalises each magnitude to 0..255.
module prewitt_frame_sequencer #(
  parameter int ROWS   = 242,
  parameter int COLS   = 247,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [10:0]               max_mag,
  prewitt_frame_sequencer_if.master bus
);
  localparam int                N         = ROWS * COLS;
  localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  // receive counter is one bit wider so it can hold N even when N == 2^ADDR_W
  localparam logic [ADDR_W:0]   N_CNT     = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE, P1, P1_DRAIN, P2_RD, P2_DAT, P2_DIV, P2_WR, DONE
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] rd_row_r, rd_col_r;
  logic              rd_pend_r;
  logic [ADDR_W-1:0] pend_row_r, pend_col_r;
  logic [ADDR_W:0]   m_cnt_r;
  logic [ADDR_W-1:0] m_row_r, m_col_r;
  logic              start_ok_s;
  logic              cap_ok_s;
  logic [10:0]       cap_val_s;

  function automatic logic is_border(input logic [ADDR_W-1:0] row,
                                     input logic [ADDR_W-1:0] col);
    return (row == ZERO_A) || (row == LAST_ROW) ||
           (col == ZERO_A) || (col == LAST_COL);
  endfunction

  assign start_ok_s = (state_r == IDLE) && start;
  assign cap_ok_s   = ((state_r == P1) || (state_r == P1_DRAIN)) &&
                      bus.mag_valid && (m_cnt_r != N_CNT);

  // value stored for the current magnitude beat: border pixels become 0
  always_comb begin
    cap_val_s = 11'd0;
    if (is_border(m_row_r, m_col_r)) begin
      cap_val_s = 11'd0;
    end else begin
      cap_val_s = bus.mag;
    end
  end

  // main sequencer: pass-1 read addressing, pass-2 read/divide/write, status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      rd_row_r        <= ZERO_A;
      rd_col_r        <= ZERO_A;
      bus.in_rd_en    <= 1'b0;
      bus.in_rd_addr  <= ZERO_A;
      bus.mid_rd_en   <= 1'b0;
      bus.mid_rd_addr <= ZERO_A;
      bus.div_req     <= 1'b0;
      bus.div_num     <= 19'd0;
      bus.div_den     <= 11'd0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_addr <= ZERO_A;
      bus.out_wr_data <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r        <= P1;
            busy           <= 1'b1;
            bus.in_rd_en   <= 1'b1;
            bus.in_rd_addr <= ZERO_A;
            rd_row_r       <= ZERO_A;
            rd_col_r       <= ZERO_A;
          end
        end
        P1: begin
          if (bus.in_rd_addr == LAST_ADDR) begin
            bus.in_rd_en <= 1'b0;
            state_r      <= P1_DRAIN;
          end else begin
            bus.in_rd_addr <= bus.in_rd_addr + ONE_A;
            if (rd_col_r == LAST_COL) begin
              rd_col_r <= ZERO_A;
              rd_row_r <= rd_row_r + ONE_A;
            end else begin
              rd_col_r <= rd_col_r + ONE_A;
            end
          end
        end
        P1_DRAIN: begin
          if (m_cnt_r == N_CNT) begin
            state_r         <= P2_RD;
            bus.mid_rd_en   <= 1'b1;
            bus.mid_rd_addr <= ZERO_A;
          end
        end
        P2_RD: begin
          bus.mid_rd_en <= 1'b0;
          state_r       <= P2_DAT;
        end
        P2_DAT: begin
          if ((bus.mid_rd_data == 11'd0) || (max_mag == 11'd0)) begin
            bus.out_wr_en   <= 1'b1;
            bus.out_wr_addr <= bus.mid_rd_addr;
            bus.out_wr_data <= 8'd0;
            state_r         <= P2_WR;
          end else begin
            bus.div_req <= 1'b1;
            bus.div_num <= 19'(bus.mid_rd_data) * 19'd255;
            bus.div_den <= max_mag;
            state_r     <= P2_DIV;
          end
        end
        P2_DIV: begin
          if (bus.div_ack) begin
            bus.div_req     <= 1'b0;
            bus.out_wr_en   <= 1'b1;
            bus.out_wr_addr <= bus.mid_rd_addr;
            bus.out_wr_data <= bus.div_quot;
            state_r         <= P2_WR;
          end
        end
        P2_WR: begin
          bus.out_wr_en <= 1'b0;
          if (bus.mid_rd_addr == LAST_ADDR) begin
            state_r <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            bus.mid_rd_addr <= bus.mid_rd_addr + ONE_A;
            bus.mid_rd_en   <= 1'b1;
            state_r         <= P2_RD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // pixel stream: two register stages so row/col line up with RAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r    <= 1'b0;
      pend_row_r   <= ZERO_A;
      pend_col_r   <= ZERO_A;
      bus.px_valid <= 1'b0;
      bus.px_data  <= 8'd0;
      bus.px_row   <= ZERO_A;
      bus.px_col   <= ZERO_A;
    end else begin
      rd_pend_r    <= bus.in_rd_en;
      pend_row_r   <= rd_row_r;
      pend_col_r   <= rd_col_r;
      bus.px_valid <= rd_pend_r;
      if (rd_pend_r) begin
        bus.px_data <= bus.in_rd_data;
        bus.px_row  <= pend_row_r;
        bus.px_col  <= pend_col_r;
      end
    end
  end

  // magnitude capture into the intermediate RAM and running frame maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt_r         <= {(ADDR_W + 1){1'b0}};
      m_row_r         <= ZERO_A;
      m_col_r         <= ZERO_A;
      max_mag         <= 11'd0;
      bus.mid_wr_en   <= 1'b0;
      bus.mid_wr_addr <= ZERO_A;
      bus.mid_wr_data <= 11'd0;
    end else begin
      bus.mid_wr_en <= 1'b0;
      if (start_ok_s) begin
        m_cnt_r <= {(ADDR_W + 1){1'b0}};
        m_row_r <= ZERO_A;
        m_col_r <= ZERO_A;
        max_mag <= 11'd0;
      end else if (cap_ok_s) begin
        bus.mid_wr_en   <= 1'b1;
        bus.mid_wr_addr <= m_cnt_r[ADDR_W-1:0];
        bus.mid_wr_data <= cap_val_s;
        if (cap_val_s > max_mag) begin
          max_mag <= cap_val_s;
        end
        m_cnt_r <= m_cnt_r + ONE_C;
        if (m_col_r == LAST_COL) begin
          m_col_r <= ZERO_A;
          m_row_r <= m_row_r + ONE_A;
        end else begin
          m_col_r <= m_col_r + ONE_A;
        end
      end
    end
  end
endmodule

// File: tb/tb_prewitt_frame_sequencer.sv
// Directed self-checking bench for prewitt_frame_sequencer on a 4x5 frame
// with behavioural RAMs, a queued gradient model and a delayed divider.
module tb_prewitt_frame_sequencer;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int N    = ROWS * COLS;
  localparam int AW   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [10:0] max_mag;

  prewitt_frame_sequencer_if #(.ADDR_W(AW)) bus_if ();

  prewitt_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .max_mag(max_mag), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int lat_cfg, ackd_cfg, mode_cfg;
  int cyc = 0;

  logic [7:0]  img     [N];
  logic [10:0] mid_mem [N];
  logic [7:0]  out_mem [N];
  logic [7:0]  out_ref [N];
  logic [7:0]  in_pend;
  logic [10:0] mid_pend;

  int rd_cnt, rd_first, rd_last, rd_bad, px_cnt, px_bad, out_cnt;
  int div_cnt, ack_cnt, stab_err, done_cnt, p2_first, done_cyc, wait_n;
  bit          in_req;
  logic [18:0] hold_num, first_num;
  logic [10:0] hold_den, first_den;

  typedef struct { int due; logic [10:0] val; } ent_t;
  ent_t gq[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] grad_val(input int md, input int r, input int c);
    case (md)
      1:       return (r == 1 && c == 1) ? 11'd100 : 11'd0;
      2:       return 11'd50;
      3:       return 11'(r * 5 + c * 3 + 1);
      default: return 11'd0;
    endcase
  endfunction

  function automatic int stored_val(input int md, input int k);
    int r, c;
    r = k / COLS;
    c = k % COLS;
    if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 0;
    return int'(grad_val(md, r, c));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // input and intermediate RAMs: read data appears one cycle after the request
  always @(negedge clk) begin
    int a;
    if (rst) begin
      bus_if.in_rd_data  = 8'd0;
      bus_if.mid_rd_data = 11'd0;
      in_pend = 8'd0;
      mid_pend = 11'd0;
    end else begin
      bus_if.in_rd_data  = in_pend;
      bus_if.mid_rd_data = mid_pend;
      a = int'(bus_if.in_rd_addr);
      in_pend = (bus_if.in_rd_en && a < N) ? img[a] : 8'd0;
      a = int'(bus_if.mid_wr_addr);
      if (bus_if.mid_wr_en && a < N) mid_mem[a] = bus_if.mid_wr_data;
      a = int'(bus_if.mid_rd_addr);
      mid_pend = (bus_if.mid_rd_en && a < N) ? mid_mem[a] : 11'd0;
    end
  end

  // gradient model: one magnitude per pixel, lat_cfg cycles later
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      gq.delete();
      bus_if.mag_valid = 1'b0;
      bus_if.mag = 11'd0;
    end else begin
      if (bus_if.px_valid) begin
        e.due = cyc + lat_cfg;
        e.val = grad_val(mode_cfg, int'(bus_if.px_row), int'(bus_if.px_col));
        gq.push_back(e);
      end
      if (gq.size() > 0 && gq[0].due <= cyc) begin
        bus_if.mag_valid = 1'b1;
        bus_if.mag = gq[0].val;
        void'(gq.pop_front());
      end else begin
        bus_if.mag_valid = 1'b0;
        bus_if.mag = 11'd0;
      end
    end
  end

  // divider model: acks after ackd_cfg request cycles, checks operand stability
  always @(negedge clk) begin
    if (rst || !bus_if.div_req) begin
      in_req = 1'b0;
      bus_if.div_ack = 1'b0;
      bus_if.div_quot = 8'd0;
    end else begin
      if (!in_req) begin
        in_req = 1'b1;
        wait_n = 0;
        hold_num = bus_if.div_num;
        hold_den = bus_if.div_den;
        if (div_cnt == 0) begin
          first_num = bus_if.div_num;
          first_den = bus_if.div_den;
        end
        div_cnt++;
      end else if (bus_if.div_num !== hold_num || bus_if.div_den !== hold_den) begin
        stab_err++;
      end
      if (wait_n == ackd_cfg) begin
        bus_if.div_ack = 1'b1;
        bus_if.div_quot = (hold_den == 11'd0) ? 8'd0 : 8'(hold_num / 19'(hold_den));
        ack_cnt++;
      end else begin
        bus_if.div_ack = 1'b0;
        wait_n++;
      end
    end
  end

  // monitor: read sequence, pixel stream, output writes, pass-2 timing, done
  always @(negedge clk) begin
    int a;
    if (!rst) begin
      if (bus_if.in_rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        if (int'(bus_if.in_rd_addr) != rd_cnt) rd_bad++;
        rd_cnt++;
      end
      if (bus_if.px_valid) begin
        a = int'(bus_if.px_row) * COLS + int'(bus_if.px_col);
        px_cnt++;
        if (a >= N || bus_if.px_data !== img[a]) px_bad++;
      end
      a = int'(bus_if.out_wr_addr);
      if (bus_if.out_wr_en) begin
        out_cnt++;
        if (a < N) out_mem[a] = bus_if.out_wr_data;
      end
      if (bus_if.mid_rd_en && p2_first < 0) p2_first = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic outputs_any();
    return busy | done | (|max_mag) | bus_if.in_rd_en | (|bus_if.in_rd_addr) |
           bus_if.px_valid | (|bus_if.px_data) | (|bus_if.px_row) | (|bus_if.px_col) |
           bus_if.mid_wr_en | (|bus_if.mid_wr_addr) | (|bus_if.mid_wr_data) |
           bus_if.mid_rd_en | (|bus_if.mid_rd_addr) | bus_if.div_req |
           (|bus_if.div_num) | (|bus_if.div_den) | bus_if.out_wr_en |
           (|bus_if.out_wr_addr) | (|bus_if.out_wr_data);
  endfunction

  task automatic clear_stats();
    rd_cnt = 0; rd_first = 0; rd_last = 0; rd_bad = 0; px_cnt = 0; px_bad = 0;
    out_cnt = 0; div_cnt = 0; ack_cnt = 0; stab_err = 0; done_cnt = 0;
    p2_first = -1; done_cyc = 0;
    for (int k = 0; k < N; k++) begin
      mid_mem[k] = 11'h7ff;
      out_mem[k] = 8'haa;
    end
  endtask

  task automatic run_frame(input int lat, input int ackd, input int md, input bit inject);
    bit timeout;
    bit p2_inj;
    lat_cfg = lat; ackd_cfg = ackd; mode_cfg = md;
    clear_stats();
    timeout = 1'b1;
    p2_inj = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_value("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        check_value("busy_at_done", 32'(busy), 32'd0);
        if (inject) start = 1'b1;
        timeout = 1'b0;
        break;
      end
      if (inject && bus_if.mid_rd_en && !p2_inj) begin
        start = 1'b1;
        p2_inj = 1'b1;
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check_value("timeout", 32'(timeout), 32'd0);
    check_value("busy_idle", 32'(busy), 32'd0);
    check_value("done_once", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_frame(input int md, input int ackd);
    int e_max, e_div, e_p2, mid_bad, out_bad, sv, eo;
    e_max = 0; e_div = 0; e_p2 = 0; mid_bad = 0; out_bad = 0;
    for (int k = 0; k < N; k++) if (stored_val(md, k) > e_max) e_max = stored_val(md, k);
    for (int k = 0; k < N; k++) begin
      sv = stored_val(md, k);
      eo = (sv == 0 || e_max == 0) ? 0 : (sv * 255) / e_max;
      if (mid_mem[k] !== 11'(sv)) mid_bad++;
      if (out_mem[k] !== 8'(eo)) out_bad++;
      if (sv != 0 && e_max != 0) begin
        e_div++;
        e_p2 += 4 + ackd;
      end else begin
        e_p2 += 3;
      end
    end
    check_value("rd_count", 32'(rd_cnt), 32'(N));
    check_value("rd_span", 32'(rd_last - rd_first), 32'(N - 1));
    check_value("rd_addr_seq", 32'(rd_bad), 32'd0);
    check_value("px_count", 32'(px_cnt), 32'(N));
    check_value("px_data", 32'(px_bad), 32'd0);
    check_value("max_mag", 32'(max_mag), 32'(e_max));
    check_value("mid_contents", 32'(mid_bad), 32'd0);
    check_value("out_contents", 32'(out_bad), 32'd0);
    check_value("out_writes", 32'(out_cnt), 32'(N));
    check_value("div_reqs", 32'(div_cnt), 32'(e_div));
    check_value("div_acks", 32'(ack_cnt), 32'(e_div));
    check_value("div_stable", 32'(stab_err), 32'd0);
    check_value("p2_cycles", 32'(done_cyc - p2_first), 32'(e_p2));
  endtask

  initial begin
    int diffs;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; start = 1'b0;
    lat_cfg = 0; ackd_cfg = 0; mode_cfg = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check_value("reset_outputs", 32'(outputs_any()), 32'd0);
    rst = 1'b0;

    // all-zero gradient on a constant image: everything bypasses the divider
    for (int k = 0; k < N; k++) img[k] = 8'd7;
    run_frame(0, 0, 0, 1'b0);
    check_frame(0, 0);

    // single interior spot of 100 at (1,1)
    for (int k = 0; k < N; k++) img[k] = 8'(k * 11 + 3);
    run_frame(3, 0, 1, 1'b0);
    check_frame(1, 0);
    check_value("spot_num", 32'(first_num), 32'd25500);
    check_value("spot_den", 32'(first_den), 32'd100);
    check_value("spot_out6", 32'(out_mem[6]), 32'd255);

    // constant 50: border forced to 0, interior normalises to 255
    run_frame(2, 0, 2, 1'b0);
    check_frame(2, 0);

    // same with a 7-cycle divider acknowledge delay
    run_frame(2, 7, 2, 1'b0);
    check_frame(2, 7);

    // reset in the 10th pass-1 cycle, then a full clean frame
    clear_stats();
    lat_cfg = 0; ackd_cfg = 0; mode_cfg = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check_value("p1_cycle10_addr", 32'(bus_if.in_rd_addr), 32'd9);
    check_value("p1_cycle10_max", 32'(max_mag), 32'd50);
    rst = 1'b1;
    @(negedge clk);
    check_value("abort_outputs", 32'(outputs_any()), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_frame(0, 0, 2, 1'b0);
    check_frame(2, 0);

    // graded magnitudes at latency 0 and 12, stray starts on the second run
    run_frame(0, 1, 3, 1'b0);
    check_frame(3, 1);
    for (int k = 0; k < N; k++) out_ref[k] = out_mem[k];
    run_frame(12, 1, 3, 1'b1);
    check_frame(3, 1);
    diffs = 0;
    for (int k = 0; k < N; k++) if (out_mem[k] !== out_ref[k]) diffs++;
    check_value("latency_match", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
